// File: rtl/risc16b_mem_pkg.sv
// Shared types for the risc16b unified memory and boot loader.
// The state enum and the byte-lane numbering are shared by the top level and the RAM.
package risc16b_mem_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Big-endian lanes: the even byte lives in [15:8], the odd byte in [7:0].
  localparam int LANE_EVEN = 0;
  localparam int LANE_ODD  = 1;

  function automatic logic [1:0] lane_mask(input logic odd_byte);
    logic [1:0] m;
    m = '0;
    if (odd_byte) m[LANE_ODD] = 1'b1;
    else          m[LANE_EVEN] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mem_ram16.sv
// DEPTH_WORDS x 16 storage with two asynchronous read ports and one
// byte-lane-masked write port.
module mem_ram16
  import risc16b_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32768,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] ra_idx,
  output logic [15:0]   ra_data,
  input  logic [AW-1:0] rb_idx,
  output logic [15:0]   rb_data,
  input  logic [1:0]    we,
  input  logic [AW-1:0] w_idx,
  input  logic [15:0]   w_data
);

  logic [15:0] mem [DEPTH_WORDS];

  assign ra_data = mem[ra_idx];
  assign rb_data = mem[rb_idx];

  // NOTE: the array has no reset on purpose; contents must survive rst_n, and
  // a reset would also keep the storage from mapping onto RAM macros.
  // NOTE: sequential state is always written with <=, so same-edge readers see the old value.
  always_ff @(posedge clk) begin
    if (we[LANE_EVEN]) mem[w_idx][15:8] <= w_data[15:8];
    if (we[LANE_ODD])  mem[w_idx][7:0]  <= w_data[7:0];
  end

endmodule

// File: rtl/risc16b_mem.sv
// Unified fetch/data memory for the risc16b core with a byte-serial boot
// loader that holds the core in reset until the host image is in place.
module risc16b_mem
  import risc16b_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32768,
  parameter int BOOT_LOAD   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_ovf,
  output logic        cpu_rst
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // One bit beyond the byte address so the saturated count DEPTH_WORDS*2 is representable.
  localparam int BW = AW + 2;
  localparam logic [BW-1:0] BPTR_FULL   = BW'(DEPTH_WORDS * 2);
  localparam state_e        RESET_STATE = (BOOT_LOAD != 0) ? LOAD : RELEASE;

  state_e        state_q, state_d;
  logic [BW-1:0] bptr_q, bptr_d;
  logic          ld_ready_q, ld_ready_d;
  logic          ld_ovf_q, ld_ovf_d;

  logic [AW-1:0] i_idx, d_idx, w_idx;
  logic [15:0]   i_word, d_word, w_data;
  logic [1:0]    w_en;
  logic          accept;
  logic          unused_addr_bits;

  assign i_idx  = i_addr[AW:1];
  assign d_idx  = d_addr[AW:1];
  assign accept = ld_valid & ld_ready_q & (state_q == LOAD);
  // Bit 0 and the bits above the array size are address don't-cares (wrap).
  assign unused_addr_bits = ^{i_addr, d_addr};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bptr_d   = bptr_q;
    ld_ovf_d = ld_ovf_q;
    w_en     = '0;
    w_idx    = d_idx;
    w_data   = d_dout;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (bptr_q == BPTR_FULL) begin
            ld_ovf_d = 1'b1;
          end else begin
            w_en   = lane_mask(bptr_q[0]);
            w_idx  = bptr_q[AW:1];
            w_data = {ld_data, ld_data};
            bptr_d = bptr_q + BW'(1);
          end
          if (ld_last) state_d = RELEASE;
        end
      end
      RELEASE: state_d = RUN;
      RUN:     w_en    = d_we;
      default: state_d = RESET_STATE;
    endcase
    ld_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      bptr_q     <= '0;
      ld_ready_q <= 1'b0;
      ld_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bptr_q     <= bptr_d;
      ld_ready_q <= ld_ready_d;
      ld_ovf_q   <= ld_ovf_d;
    end
  end

  mem_ram16 #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .ra_idx  (i_idx),
    .ra_data (i_word),
    .rb_idx  (d_idx),
    .rb_data (d_word),
    .we      (w_en),
    .w_idx   (w_idx),
    .w_data  (w_data)
  );

  // Reads are blanked while the image is still streaming in.
  assign i_din    = (i_oe && state_q != LOAD) ? i_word : 16'h0000;
  assign d_din    = (d_oe && state_q != LOAD) ? d_word : 16'h0000;
  assign ld_ready = ld_ready_q;
  assign ld_ovf   = ld_ovf_q;
  assign cpu_rst  = (state_q != RUN);

endmodule

// File: tb/tb_risc16b_mem.sv
// Directed bench for risc16b_mem: three instances (16K-word boot, 4-word boot,
// 16-word no-boot) checked through an expected-value queue.
module tb_risc16b_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n_v, ldv_v, rdy, ovf, crst;
  logic [15:0] i_addr, d_addr, d_dout;
  logic        i_oe, d_oe, ld_last;
  logic [7:0]  ld_data;
  logic [1:0]  dwe  [3];
  logic [15:0] idin [3];
  logic [15:0] ddin [3];

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  risc16b_mem #(.DEPTH_WORDS(16384), .BOOT_LOAD(1)) dut_a (
    .clk(clk), .rst_n(rst_n_v[0]),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(idin[0]),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(ddin[0]), .d_dout(d_dout), .d_we(dwe[0]),
    .ld_valid(ldv_v[0]), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy[0]), .ld_ovf(ovf[0]), .cpu_rst(crst[0])
  );

  risc16b_mem #(.DEPTH_WORDS(4), .BOOT_LOAD(1)) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(idin[1]),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(ddin[1]), .d_dout(d_dout), .d_we(dwe[1]),
    .ld_valid(ldv_v[1]), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy[1]), .ld_ovf(ovf[1]), .cpu_rst(crst[1])
  );

  risc16b_mem #(.DEPTH_WORDS(16), .BOOT_LOAD(0)) dut_c (
    .clk(clk), .rst_n(rst_n_v[2]),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(idin[2]),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(ddin[2]), .d_dout(d_dout), .d_we(dwe[2]),
    .ld_valid(ldv_v[2]), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(rdy[2]), .ld_ovf(ovf[2]), .cpu_rst(crst[2])
  );

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [15:0] obs);
    exp_t e;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed %h with no expected value queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  // Inputs change 2 ns after the active edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one byte to instance w and wait (bounded) for the handshake edge.
  task automatic send(input int w, input logic [7:0] b, input logic last);
    bit done;
    done    = 1'b0;
    ld_data = b;
    ld_last = last;
    ldv_v[w] = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (rdy[w]) done = 1'b1;
      @(posedge clk);
      #2;
    end
    ldv_v[w] = 1'b0;
    ld_last  = 1'b0;
    if (!done) begin
      push("send_timeout", 16'h0001);
      observe({15'd0, rdy[w]});
    end
  endtask

  initial begin
    rst_n_v = '0; ldv_v = '0;
    i_addr = '0; d_addr = '0; d_dout = '0;
    i_oe = 1'b0; d_oe = 1'b0; ld_last = 1'b0; ld_data = '0;
    for (int i = 0; i < 3; i++) dwe[i] = 2'b00;
    step(); step();

    // Reset values.
    push("a_rdy_in_reset", 16'h0000);  #1 observe({15'd0, rdy[0]});
    push("a_ovf_in_reset", 16'h0000);  observe({15'd0, ovf[0]});
    push("a_crst_in_reset", 16'h0001); observe({15'd0, crst[0]});
    push("c_crst_in_reset", 16'h0001); observe({15'd0, crst[2]});

    // Boot 12 34 AB CD on the 16K-word instance.
    step();
    rst_n_v[0] = 1'b1;
    push("a_rdy_before_edge", 16'h0000); #1 observe({15'd0, rdy[0]});
    step();
    push("a_rdy_after_edge", 16'h0001);  #1 observe({15'd0, rdy[0]});
    i_oe = 1'b1; i_addr = 16'h0000;
    push("a_fetch_blank_in_load", 16'h0000); #1 observe(idin[0]);
    send(0, 8'h12, 1'b0);
    send(0, 8'h34, 1'b0);
    send(0, 8'hAB, 1'b0);
    send(0, 8'hCD, 1'b1);
    push("a_crst_release", 16'h0001); #1 observe({15'd0, crst[0]});
    push("a_rdy_after_last", 16'h0000); observe({15'd0, rdy[0]});
    step();
    push("a_crst_run", 16'h0000); #1 observe({15'd0, crst[0]});
    step();
    i_addr = 16'h0000;
    push("a_fetch_w0", 16'h1234); #1 observe(idin[0]);
    i_addr = 16'h0002;
    push("a_fetch_w1", 16'hABCD); #1 observe(idin[0]);
    d_addr = 16'h0002; d_oe = 1'b1;
    push("a_load_w1", 16'hABCD); #1 observe(ddin[0]);

    // CPU byte-lane writes to 0x0100.
    step();
    d_addr = 16'h0100; d_dout = 16'h5555; dwe[0] = 2'b11;
    step();
    d_dout = 16'hAA00; dwe[0] = 2'b01;
    step();
    d_dout = 16'h00BB; dwe[0] = 2'b10;
    push("a_same_cycle_old", 16'hAA55); #1 observe(ddin[0]);
    step();
    dwe[0] = 2'b00;
    push("a_lane_merge", 16'hAABB); #1 observe(ddin[0]);

    // Output enables low, then address aliasing.
    step();
    i_oe = 1'b0; d_oe = 1'b0; i_addr = 16'h0000; d_addr = 16'h0100;
    push("a_ioe_low", 16'h0000); #1 observe(idin[0]);
    push("a_doe_low", 16'h0000); observe(ddin[0]);
    step();
    d_addr = 16'h0004; d_dout = 16'h1357; dwe[0] = 2'b11;
    step();
    dwe[0] = 2'b00; d_addr = 16'h8004; d_oe = 1'b1; i_addr = 16'h8000; i_oe = 1'b1;
    push("a_alias_d", 16'h1357); #1 observe(ddin[0]);
    push("a_alias_i", 16'h1234); observe(idin[0]);

    // 4-word instance: 9 bytes, the 9th overflows.
    step();
    rst_n_v[1] = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) send(1, 8'(i * 17), 1'b0);
    push("b_ovf_before", 16'h0000); #1 observe({15'd0, ovf[1]});
    send(1, 8'h99, 1'b1);
    push("b_ovf_after", 16'h0001); #1 observe({15'd0, ovf[1]});
    step();
    push("b_crst_run", 16'h0000); #1 observe({15'd0, crst[1]});
    i_oe = 1'b1; i_addr = 16'h0000;
    push("b_w0_kept", 16'h1122); #1 observe(idin[1]);
    i_addr = 16'h0006;
    push("b_w3", 16'h7788); #1 observe(idin[1]);

    // Reset in the middle of a reload.
    step();
    rst_n_v[1] = 1'b0;
    push("b_rdy_rst", 16'h0000);  #1 observe({15'd0, rdy[1]});
    push("b_ovf_rst", 16'h0000);  observe({15'd0, ovf[1]});
    push("b_crst_rst", 16'h0001); observe({15'd0, crst[1]});
    step();
    rst_n_v[1] = 1'b1;
    push("b_rdy_before_edge", 16'h0000); #1 observe({15'd0, rdy[1]});
    step();
    push("b_rdy_after_edge", 16'h0001);  #1 observe({15'd0, rdy[1]});
    send(1, 8'h01, 1'b0);
    send(1, 8'h02, 1'b0);
    send(1, 8'h03, 1'b0);
    rst_n_v[1] = 1'b0;
    push("b_rdy_midload_rst", 16'h0000); #1 observe({15'd0, rdy[1]});
    step();
    rst_n_v[1] = 1'b1;
    step();
    send(1, 8'hFF, 1'b0);
    send(1, 8'hEE, 1'b1);
    step();
    i_addr = 16'h0000;
    push("b_reload_w0", 16'hFFEE); #1 observe(idin[1]);
    i_addr = 16'h0002;
    push("b_reload_w1", 16'h0344); #1 observe(idin[1]);

    // No-boot instance: one RELEASE cycle, host input ignored.
    step();
    push("c_rdy_rst", 16'h0000); #1 observe({15'd0, rdy[2]});
    step();
    rst_n_v[2] = 1'b1;
    push("c_crst_release", 16'h0001); #1 observe({15'd0, crst[2]});
    step();
    push("c_crst_run", 16'h0000); #1 observe({15'd0, crst[2]});
    d_addr = 16'h0000; d_dout = 16'h0F0F; dwe[2] = 2'b11;
    step();
    dwe[2] = 2'b00;
    ld_data = 8'h77; ld_last = 1'b1; ldv_v[2] = 1'b1;
    step(); step();
    push("c_rdy_run", 16'h0000); #1 observe({15'd0, rdy[2]});
    step();
    ldv_v[2] = 1'b0; ld_last = 1'b0;
    d_addr = 16'h0000; d_oe = 1'b1; i_addr = 16'h0001; i_oe = 1'b1;
    push("c_mem_untouched_d", 16'h0F0F); #1 observe(ddin[2]);
    push("c_mem_untouched_i", 16'h0F0F); observe(idin[2]);
    push("c_ovf_run", 16'h0000); observe({15'd0, ovf[2]});

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover: observed %0d queued expect 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
